key_debounce_repeat: RTL and testbench
======================================

Name: key_debounce_repeat

Overview:
- Conditions the active-low DE10-Lite push-buttons before they reach the key PIO of the Qsys system (key_external_connection_export, 2 bits).
- Per key: 2-flop synchronizer, counter-based debounce FSM, one-cycle press/release strobes and optional auto-repeat strobes.
- Sits between the board KEY pins and the Qsys top; the strobes also feed the HW timer fabric directly.

Parameters:
- NUM_KEYS, 2, number of independent keys.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles to accept a level change (20 ms at 50 MHz); legal range >=2.
- REPEAT_DELAY, 25000000, cycles held before the first repeat strobe (500 ms).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (100 ms); legal range >=1.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  asynchronous active-low reset.
- key_n_raw  in  NUM_KEYS  raw KEY pins, active-low, asynchronous to clk_clk.
- repeat_en  in  1  enables auto-repeat for all keys.
- key_clean_n  out  NUM_KEYS  debounced level, active-low; drives key_external_connection_export.
- press_pulse  out  NUM_KEYS  one-cycle strobe on accepted press.
- release_pulse  out  NUM_KEYS  one-cycle strobe on accepted release.
- repeat_pulse  out  NUM_KEYS  one-cycle auto-repeat strobe.

Behaviour:
- Reset (async assert, sync release): synchronizers = all 1s, every FSM in IDLE, all counters 0.
- Reset output values: key_clean_n all 1s; all pulses 0.
- Reset asserted mid-operation forces these values immediately, with no pulse emitted.
- Synchronizer: two flops per key; FSM sees s = second flop.
- Counters are sized to the max of the parameters. Each key is fully independent, and keys may change in the same cycle.
- IDLE: key_clean_n=1, deb counter 0. If s=0, go to CONF_PRESS with deb=1.
- CONF_PRESS:
  - If s=1: return to IDLE, deb=0, no pulse.
  - Else if deb==DEBOUNCE_CYCLES-1: go to HELD, key_clean_n<=0, press_pulse=1 for that one cycle, rpt=0.
  - Else deb++.
- HELD:
  - key_clean_n=0.
  - If s=1: go to CONF_REL, deb=1.
  - Repeat counting, only while repeat_en=1:
    - rpt++ each cycle.
    - When rpt reaches REPEAT_DELAY-1: repeat_pulse=1 and load rpt with REPEAT_DELAY-REPEAT_PERIOD.
    - This gives the first strobe REPEAT_DELAY cycles after the press_pulse cycle, then one every REPEAT_PERIOD cycles.
  - While repeat_en=0: rpt held at 0. Reasserting repeat_en restarts the full REPEAT_DELAY.
- CONF_REL:
  - key_clean_n stays 0; rpt frozen; no repeat strobes.
  - If s=0: return to HELD with rpt unchanged, no press_pulse.
  - Else if deb==DEBOUNCE_CYCLES-1: go to IDLE, key_clean_n<=1, release_pulse=1 for one cycle.
  - Else deb++.
- Latency: a raw change held stable is reflected on key_clean_n/pulses on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples it.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no output activity.
- press_pulse and release_pulse never coincide for one key. repeat_pulse never coincides with press_pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold reset_reset_n=0 with key_n_raw=2'b00 -> key_clean_n=2'b11, all pulses 0. Release reset, hold keys low -> key_clean_n=2'b00 and press_pulse=2'b11 exactly at edge 6, for one cycle.
- Bounce: key0 toggles low/high every 2 cycles for 20 cycles, then high -> no pulses; key_clean_n[0] stays 1.
- Press/release: key1 low for 30 cycles then high, repeat_en=0 -> press_pulse[1] once, release_pulse[1] 6 edges after release, no repeat_pulse.
- Auto-repeat: repeat_en=1, key0 held 25 cycles after press_pulse -> repeat_pulse[0] at +10, +13, +16, +19, +22, +25.
- Release glitch: during HELD, key0 high for 3 cycles then low -> no release_pulse, no second press_pulse; the repeat schedule is shifted by the frozen cycles.
- Async reset mid-CONF_REL -> outputs return to reset values within the same cycle; after release, no stale pulses.

Source files
------------

// File: rtl/key_debounce_repeat.sv
// rtl/key_debounce_repeat.sv - per-key synchronizer, debounce FSM and press/release/auto-repeat strobes
module key_debounce_repeat #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_n_raw,
    input  logic                repeat_en,
    output logic [NUM_KEYS-1:0] key_clean_n,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    // One shared counter width covers both the debounce and the repeat counters.
    localparam int MAX_A  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
    // Reloading with DELAY-PERIOD makes every later strobe land PERIOD cycles apart.
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONF_PRESS,
        ST_HELD,
        ST_CONF_REL
    } key_state_e;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        key_state_e       state_q;
        logic [CNT_W-1:0] deb_q;
        logic [CNT_W-1:0] rpt_q;
        logic             clean_q;
        logic             press_q;
        logic             rel_q;
        logic             rep_q;

        // Two-flop synchronizer; idles high so a reset never looks like a press.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= key_n_raw[k];
                sync2_q <= sync1_q;
            end
        end

        // Debounce FSM with registered level, strobes and auto-repeat counter.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                state_q <= ST_IDLE;
                deb_q   <= CNT_ZERO;
                rpt_q   <= CNT_ZERO;
                clean_q <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        clean_q <= 1'b1;
                        deb_q   <= CNT_ZERO;
                        if (!sync2_q) begin
                            state_q <= ST_CONF_PRESS;
                            deb_q   <= CNT_ONE;
                        end
                    end
                    ST_CONF_PRESS: begin
                        if (sync2_q) begin
                            state_q <= ST_IDLE;
                            deb_q   <= CNT_ZERO;
                        end else if (deb_q == DEB_LAST) begin
                            state_q <= ST_HELD;
                            clean_q <= 1'b0;
                            press_q <= 1'b1;
                            rpt_q   <= CNT_ZERO;
                            deb_q   <= CNT_ZERO;
                        end else begin
                            deb_q <= deb_q + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        clean_q <= 1'b0;
                        // A release candidate freezes the repeat counter this cycle.
                        if (sync2_q) begin
                            state_q <= ST_CONF_REL;
                            deb_q   <= CNT_ONE;
                        end else if (!repeat_en) begin
                            rpt_q <= CNT_ZERO;
                        end else if (rpt_q == RPT_LAST) begin
                            rep_q <= 1'b1;
                            rpt_q <= RPT_RELOAD;
                        end else begin
                            rpt_q <= rpt_q + CNT_ONE;
                        end
                    end
                    ST_CONF_REL: begin
                        clean_q <= 1'b0;
                        if (!sync2_q) begin
                            // Bounce on release: resume the hold with repeat timing intact.
                            state_q <= ST_HELD;
                            deb_q   <= CNT_ZERO;
                        end else if (deb_q == DEB_LAST) begin
                            state_q <= ST_IDLE;
                            clean_q <= 1'b1;
                            rel_q   <= 1'b1;
                            deb_q   <= CNT_ZERO;
                            rpt_q   <= CNT_ZERO;
                        end else begin
                            deb_q <= deb_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        deb_q   <= CNT_ZERO;
                        rpt_q   <= CNT_ZERO;
                        clean_q <= 1'b1;
                    end
                endcase
            end
        end

        assign key_clean_n[k]   = clean_q;
        assign press_pulse[k]   = press_q;
        assign release_pulse[k] = rel_q;
        assign repeat_pulse[k]  = rep_q;
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb/tb_key_debounce_repeat.sv - scoreboard bench for key_debounce_repeat
module tb_key_debounce_repeat;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key_n_raw;
    logic       repeat_en;
    logic [1:0] key_clean_n;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] repeat_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int stamp;
        int kind;
        int key;
    } ev_t;

    ev_t exp_q[$];

    key_debounce_repeat #(
        .NUM_KEYS       (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .key_n_raw    (key_n_raw),
        .repeat_en    (repeat_en),
        .key_clean_n  (key_clean_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            0:       return "press";
            1:       return "release";
            default: return "repeat";
        endcase
    endfunction

    // Monitor: every strobe the DUT shows must match one queued expectation.
    always @(negedge clk) begin
        logic [1:0] pv;
        int found;
        for (int kind = 0; kind < 3; kind++) begin
            pv = (kind == 0) ? press_pulse : (kind == 1) ? release_pulse : repeat_pulse;
            for (int key = 0; key < 2; key++) begin
                if (pv[key]) begin
                    found = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (found < 0 && exp_q[i].stamp == cyc && exp_q[i].kind == kind && exp_q[i].key == key)
                            found = i;
                    total++;
                    if (found >= 0) begin
                        exp_q.delete(found);
                    end else begin
                        bad++;
                        $display("FAIL unexpected %s key%0d: seen at cycle %0d, required none", kname(kind), key, cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int stamp, input int kind, input int key);
        ev_t e;
        e.stamp = stamp;
        e.kind  = kind;
        e.key   = key;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    initial begin
        int c;
        int p;
        rst_n     = 1'b0;
        key_n_raw = 2'b00;
        repeat_en = 1'b0;

        // Reset with both keys held low.
        tick(3);
        chk("reset_clean", 32'(key_clean_n), 32'h3);
        chk("reset_press", 32'(press_pulse), 32'h0);
        chk("reset_rel_rep", 32'(release_pulse | repeat_pulse), 32'h0);
        rst_n = 1'b1;
        c = cyc;
        expect_ev(c + 6, 0, 0);
        expect_ev(c + 6, 0, 1);
        tick(5);
        chk("clean_before_press", 32'(key_clean_n), 32'h3);
        tick(1);
        chk("clean_at_press", 32'(key_clean_n), 32'h0);
        tick(4);
        key_n_raw = 2'b11;
        expect_ev(c + 16, 1, 0);
        expect_ev(c + 16, 1, 1);
        tick(10);
        chk("clean_after_release", 32'(key_clean_n), 32'h3);

        // Bounce on key0: low/high every 2 cycles.
        for (int i = 0; i < 5; i++) begin
            key_n_raw[0] = 1'b0;
            tick(2);
            key_n_raw[0] = 1'b1;
            tick(2);
        end
        tick(10);
        chk("bounce_clean0", 32'(key_clean_n[0]), 32'h1);

        // Key1 press/release without repeat.
        c = cyc;
        key_n_raw[1] = 1'b0;
        expect_ev(c + 6, 0, 1);
        tick(6);
        chk("k1_clean_held", 32'(key_clean_n), 32'h1);
        tick(24);
        key_n_raw[1] = 1'b1;
        expect_ev(c + 36, 1, 1);
        tick(12);
        chk("k1_clean_idle", 32'(key_clean_n), 32'h3);

        // Auto-repeat on key0.
        repeat_en = 1'b1;
        c = cyc;
        p = c + 6;
        key_n_raw[0] = 1'b0;
        expect_ev(p, 0, 0);
        for (int i = 0; i < 6; i++) expect_ev(p + 10 + 3 * i, 2, 0);
        tick(30);
        key_n_raw[0] = 1'b1;
        expect_ev(p + 30, 1, 0);
        tick(12);
        chk("rep_clean_idle", 32'(key_clean_n), 32'h3);

        // Release glitch during HELD: repeat schedule shifts by the 4 frozen edges.
        c = cyc;
        p = c + 6;
        key_n_raw[0] = 1'b0;
        expect_ev(p, 0, 0);
        expect_ev(p + 14, 2, 0);
        expect_ev(p + 17, 2, 0);
        expect_ev(p + 20, 2, 0);
        tick(9);
        key_n_raw[0] = 1'b1;
        tick(3);
        key_n_raw[0] = 1'b0;
        tick(4);
        chk("glitch_clean_held", 32'(key_clean_n[0]), 32'h0);
        tick(8);
        key_n_raw[0] = 1'b1;
        expect_ev(p + 24, 1, 0);
        tick(12);
        repeat_en = 1'b0;
        chk("glitch_clean_idle", 32'(key_clean_n), 32'h3);

        // Async reset while key1 is confirming its release.
        c = cyc;
        key_n_raw[1] = 1'b0;
        expect_ev(c + 6, 0, 1);
        tick(10);
        key_n_raw[1] = 1'b1;
        tick(4);
        chk("confrel_clean", 32'(key_clean_n), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_clean", 32'(key_clean_n), 32'h3);
        chk("async_rst_pulses", 32'(press_pulse | release_pulse | repeat_pulse), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(15);
        chk("post_rst_clean", 32'(key_clean_n), 32'h3);

        tick(5);
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL missing %s key%0d: seen none, required at cycle %0d",
                     kname(exp_q[0].kind), exp_q[0].key, exp_q[0].stamp);
            exp_q.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
